// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a valid/ready handshake on both sides.
//
// Ports:
//   clk, rst_n            - rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   - operation offer / accept (accept only in IDLE)
//   A, B, Cin, opcode     - operands, carry-in (ADD only), operation select
//   out_valid / out_ready - result offer / consumer take (offer only in DONE)
//   Result, Z, N, C, V    - registered result and flags, held until transfer
//   illegal               - the completed opcode was undefined (1010-1111)
//
// ADD, SUB, the logic ops and illegal opcodes finish in one EXEC cycle.
// Shifts move one bit per EXEC cycle and take max(shamt,1) cycles.
// MUL is shift-add, one multiplier bit per cycle, and takes WIDTH cycles.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output logic             illegal
);

    localparam int CNT_W = SHW + 1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_NOR = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Cleared by reset and set on the first edge afterwards, so in_ready
    // stays low while rst_n is asserted even though the state is IDLE.
    logic rdy_en;

    logic accept;

    // Operation latched at accept; the shift and MUL datapaths update these
    // in place during EXEC.
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [WIDTH-1:0] hi_p0;
    logic             cin_p0;
    logic [3:0]       op_p0;
    logic [CNT_W-1:0] cnt_p0;

    // Combinational EXEC results
    logic                    fin;
    logic [WIDTH-1:0]        res_nxt;
    logic                    c_nxt;
    logic                    v_nxt;
    logic                    ill_nxt;
    logic [WIDTH-1:0]        sh_val;
    logic                    sh_out;
    logic [WIDTH:0]          mul_sum;
    logic [WIDTH+1:0]        as_r;
    logic signed [WIDTH-1:0] a_s;

    // Returns {overflow, carry, sum} of x + y + ci. Overflow is the signed
    // rule: operand MSBs agree and the sum MSB differs from them.
    function automatic logic [WIDTH+1:0] addsub(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             ci);
        logic [WIDTH:0] s;
        logic           ov;
        s  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        ov = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
        return {ov, s};
    endfunction

    assign accept = in_valid & in_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)    state_nxt = S_EXEC;
            S_EXEC:  if (fin)       state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = rdy_en && (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // ---------------- EXEC datapath (combinational) ----------------
    always_comb begin
        a_s = a_p0;

        sh_val = a_p0;
        sh_out = 1'b0;
        case (op_p0)
            OP_SLL: begin
                sh_val = {a_p0[WIDTH-2:0], 1'b0};
                sh_out = a_p0[WIDTH-1];
            end
            OP_SRL: begin
                sh_val = {1'b0, a_p0[WIDTH-1:1]};
                sh_out = a_p0[0];
            end
            OP_SRA: begin
                sh_val = a_s >>> 1;
                sh_out = a_p0[0];
            end
            default: begin
                sh_val = a_p0;
                sh_out = 1'b0;
            end
        endcase

        // One shift-add step: the multiplier LSB selects whether A is added
        // into the running upper half.
        mul_sum = {1'b0, hi_p0} + (b_p0[0] ? {1'b0, a_p0} : {(WIDTH+1){1'b0}});

        as_r = addsub(a_p0, (op_p0 == OP_SUB) ? ~b_p0 : b_p0,
                      (op_p0 == OP_SUB) ? 1'b1 : cin_p0);

        fin     = 1'b0;
        res_nxt = '0;
        c_nxt   = 1'b0;
        v_nxt   = 1'b0;
        ill_nxt = 1'b0;
        case (op_p0)
            OP_ADD, OP_SUB: begin
                fin     = 1'b1;
                res_nxt = as_r[WIDTH-1:0];
                c_nxt   = as_r[WIDTH];
                v_nxt   = as_r[WIDTH+1];
            end
            OP_XOR: begin fin = 1'b1; res_nxt = a_p0 ^ b_p0;    end
            OP_OR:  begin fin = 1'b1; res_nxt = a_p0 | b_p0;    end
            OP_AND: begin fin = 1'b1; res_nxt = a_p0 & b_p0;    end
            OP_NOR: begin fin = 1'b1; res_nxt = ~(a_p0 | b_p0); end
            OP_SLL, OP_SRL, OP_SRA: begin
                // A zero shift amount still spends one cycle and returns A.
                fin = (cnt_p0 <= CNT_W'(1));
                if (cnt_p0 == '0) begin
                    res_nxt = a_p0;
                    c_nxt   = 1'b0;
                end else begin
                    res_nxt = sh_val;
                    c_nxt   = sh_out;
                end
            end
            OP_MUL: begin
                fin     = (cnt_p0 == CNT_W'(1));
                res_nxt = {mul_sum[0], b_p0[WIDTH-1:1]};
                c_nxt   = |mul_sum[WIDTH:1];
                v_nxt   = |mul_sum[WIDTH:1];
            end
            default: begin
                fin     = 1'b1;
                ill_nxt = 1'b1;
            end
        endcase
    end

    // ---------------- Operand registers ----------------
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0   <= A;
            b_p0   <= B;
            hi_p0  <= '0;
            cin_p0 <= Cin;
            op_p0  <= opcode;
        end else if (state == S_EXEC) begin
            if ((op_p0 == OP_SLL || op_p0 == OP_SRL || op_p0 == OP_SRA) &&
                (cnt_p0 != '0)) begin
                a_p0 <= sh_val;
            end
            if (op_p0 == OP_MUL) begin
                // {hi, b} shifts right as a pair; finished product bits
                // enter b from the top while multiplier bits leave at 0.
                hi_p0 <= mul_sum[WIDTH:1];
                b_p0  <= {mul_sum[0], b_p0[WIDTH-1:1]};
            end
        end
    end

    // Iteration counter: shift amount for shifts, WIDTH for MUL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0 <= '0;
        end else if (accept) begin
            cnt_p0 <= (opcode == OP_MUL) ? CNT_W'(WIDTH) : {1'b0, B[SHW-1:0]};
        end else if ((state == S_EXEC) && (cnt_p0 != '0)) begin
            cnt_p0 <= cnt_p0 - CNT_W'(1);
        end
    end

    // ---------------- Result registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Result  <= '0;
            Z       <= 1'b0;
            N       <= 1'b0;
            C       <= 1'b0;
            V       <= 1'b0;
            illegal <= 1'b0;
        end else if ((state == S_EXEC) && fin) begin
            Result  <= res_nxt;
            Z       <= (res_nxt == '0);
            N       <= res_nxt[WIDTH-1];
            C       <= c_nxt;
            V       <= v_nxt;
            illegal <= ill_nxt;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic [3:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        Z, N, C, V, illegal;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Z(Z), .N(N), .C(C), .V(V), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        z, n, c, v, ill;
        logic [7:0]  cyc;
    } exp_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic cin);
        exp_t        e;
        longint      s;
        logic [63:0] p;
        int          sh;
        e   = '0;
        e.cyc = 8'd1;
        sh  = int'(b[4:0]);
        case (op)
            4'd0: begin
                p     = {32'b0, a} + {32'b0, b} + {63'b0, cin};
                e.res = p[31:0];
                e.c   = p[32];
                s     = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
                e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                e.res = a - b;
                e.c   = (a >= b);
                s     = longint'($signed(a)) - longint'($signed(b));
                e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: e.res = a ^ b;
            4'd3: e.res = a | b;
            4'd4: e.res = a & b;
            4'd5: e.res = ~(a | b);
            4'd6: begin
                e.res = a << sh;
                e.c   = (sh == 0) ? 1'b0 : a[32-sh];
                e.cyc = (sh == 0) ? 8'd1 : 8'(sh);
            end
            4'd7: begin
                e.res = a >> sh;
                e.c   = (sh == 0) ? 1'b0 : a[sh-1];
                e.cyc = (sh == 0) ? 8'd1 : 8'(sh);
            end
            4'd8: begin
                e.res = $signed(a) >>> sh;
                e.c   = (sh == 0) ? 1'b0 : a[sh-1];
                e.cyc = (sh == 0) ? 8'd1 : 8'(sh);
            end
            4'd9: begin
                p     = {32'b0, a} * {32'b0, b};
                e.res = p[31:0];
                e.c   = (p[63:32] != 0);
                e.v   = (p[63:32] != 0);
                e.cyc = 8'd32;
            end
            default: begin
                e.res = '0;
                e.ill = 1'b1;
            end
        endcase
        e.z = (e.res == 0);
        e.n = e.res[31];
        return e;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input int hold);
        exp_t        e;
        int          n;
        logic [31:0] r0;
        e = model(op, a, b, cin);
        n = 0;
        while (!in_ready && n < 60) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready", in_ready, 1);
        opcode   = op;
        A        = a;
        B        = b;
        Cin      = cin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble the inputs after accept; the latched operation must win.
        in_valid = 1'b0;
        A        = $urandom;
        B        = $urandom;
        Cin      = 1'($urandom);
        opcode   = 4'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check($sformatf("lat op%0d", op), n, e.cyc);
        check($sformatf("res op%0d", op), Result, e.res);
        check($sformatf("Z op%0d", op), Z, e.z);
        check($sformatf("N op%0d", op), N, e.n);
        check($sformatf("C op%0d", op), C, e.c);
        check($sformatf("V op%0d", op), V, e.v);
        check($sformatf("ill op%0d", op), illegal, e.ill);
        r0 = Result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_res", Result, r0);
            check("hold_vld", out_valid, 1);
            check("hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("xfer_vld", out_valid, 0);
    endtask

    initial begin
        int seen;
        logic [3:0] rop;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A = '0; B = '0; Cin = 1'b0; opcode = '0;
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_vld", out_valid, 0);
        check("rst_res", Result, 0);
        check("rst_flags", {Z, N, C, V, illegal}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", in_ready, 1);

        // Directed corner cases
        run_op(4'd0, 32'h7FFFFFFF, 32'd1, 1'b0, 0);
        run_op(4'd1, 32'd5, 32'd5, 1'b1, 0);
        run_op(4'd1, 32'd0, 32'd1, 1'b0, 0);
        run_op(4'd8, 32'h80000000, 32'd31, 1'b0, 0);
        run_op(4'd6, 32'd1, 32'd0, 1'b0, 0);
        run_op(4'd9, 32'h10000, 32'h10000, 1'b0, 0);
        run_op(4'd9, 32'd7, 32'd6, 1'b0, 0);
        run_op(4'd0, 32'hFFFFFFFF, 32'd0, 1'b1, 5);
        run_op(4'd15, 32'h1234, 32'h5678, 1'b1, 0);
        run_op(4'd7, 32'h80000001, 32'd1, 1'b0, 0);

        // Reset in the middle of a multiply
        opcode = 4'd9; A = 32'hFFFF; B = 32'hFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mrst_vld", out_valid, 0);
        check("mrst_res", Result, 0);
        check("mrst_flags", {Z, N, C, V, illegal}, 0);
        check("mrst_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("mrst_no_out", seen, 0);
        run_op(4'd0, 32'd2, 32'd3, 1'b0, 0);

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            run_op(rop, $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and result width in bits; legal values are powers of two, 8 to 64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount width; it is derived and not overridden.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an operation is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-007 SHALL have ports A and B, input, WIDTH bits each: the operands.
REQ-008 SHALL have port Cin, input, 1 bit: carry-in, used by ADD only.
REQ-009 SHALL have port opcode, input, 4 bits: operation select.
REQ-010 SHALL have port out_valid, output, 1 bit: Result and the flags are valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port Result, output, WIDTH bits: the registered result.
REQ-013 SHALL have ports Z, N, C, V, output, 1 bit each: the registered zero, negative, carry and overflow flags.
REQ-014 SHALL have port illegal, output, 1 bit: the completed opcode was undefined.

Function
REQ-015 SHALL accept an operation when in_valid and in_ready are both 1 at a rising clk edge, latching A, B, Cin and opcode.
REQ-016 SHALL use three states, IDLE, EXEC and DONE; in_ready = 1 only in IDLE.
REQ-017 SHALL move IDLE->EXEC on accept, EXEC->DONE on completion, and DONE->IDLE on out_valid and out_ready both 1.
REQ-018 SHALL drive out_valid = 1 only in DONE, holding Result and flags stable until the transfer; there is no accept in the same cycle as a transfer.
REQ-019 SHALL decode opcodes as follows:
- 0000 ADD = A+B+Cin.
- 0001 SUB = A+~B+1 (Cin ignored).
- 0010 XOR, 0011 OR, 0100 AND, 0101 NOR.
- 0110 SLL, 0111 SRL, 1000 SRA, each by B[SHW-1:0].
- 1001 MUL = low WIDTH bits of the unsigned product A*B.
REQ-020 SHALL complete ADD, SUB and the logic ops in one EXEC cycle, so out_valid rises on the 2nd edge after accept.
REQ-021 SHALL perform shifts iteratively, 1 bit per EXEC cycle, taking max(shamt,1) EXEC cycles; shamt = 0 returns A unchanged.
REQ-022 SHALL perform MUL by shift-add, 1 multiplier bit per cycle, taking exactly WIDTH EXEC cycles.
REQ-023 SHALL set Z = (Result == 0) and N = Result[WIDTH-1] for every opcode.
REQ-024 SHALL set C and V for ADD and SUB as follows:
- C = carry out of the MSB; for SUB, C = 1 means no borrow.
- V = signed overflow: operand MSBs equal to each other and Result MSB differing (B inverted for SUB).
REQ-025 SHALL set C for shifts to the last bit shifted out (0 when shamt = 0), and V = 0.
REQ-026 SHALL set, for MUL, C = V = 1 when the upper WIDTH product bits are nonzero, else 0.
REQ-027 SHALL set C = V = 0 for the logic ops.
REQ-028 SHALL, for opcodes 1010-1111, complete in one cycle with Result = 0, Z = 1, N = C = V = 0 and illegal = 1; illegal = 0 otherwise.
REQ-029 SHALL ignore changes on A, B, Cin and opcode after accept.

Reset
REQ-030 SHALL, on rst_n = 0, immediately and asynchronously force state IDLE.
REQ-031 SHALL, on rst_n = 0, force out_valid = 0, Result = 0, Z = N = C = V = 0 and illegal = 0.
REQ-032 SHALL drive in_ready = 0 while rst_n = 0 and 1 from the first edge after release.
REQ-033 SHALL, on reset during EXEC or DONE, abandon the operation, with no output produced after release.

Verification
REQ-034 SHALL cover: WIDTH=32, ADD A=0x7FFFFFFF, B=1, Cin=0 -> Result=0x80000000, N=1, V=1, C=0, Z=0, out_valid on the 2nd edge.
REQ-035 SHALL cover: SUB A=5, B=5 -> Result=0, Z=1, C=1, V=0; SUB A=0, B=1 -> Result=0xFFFFFFFF, C=0, N=1.
REQ-036 SHALL cover: SRA A=0x80000000, B=31 -> Result=0xFFFFFFFF after 31 EXEC cycles, C=0; SLL A=1, B=0 -> Result=1 in 1 EXEC cycle.
REQ-037 SHALL cover: MUL A=0x10000, B=0x10000 -> Result=0, Z=1, C=V=1 after 32 EXEC cycles; MUL 7*6 -> 42, C=0.
REQ-038 SHALL cover: out_ready held 0 for 5 cycles in DONE -> Result stable and in_ready=0 throughout; illegal opcode 1111 -> illegal=1, Result=0.
REQ-039 SHALL cover: rst_n pulsed low mid-MUL -> outputs zero at once, no out_valid after release, next ADD 2+3 -> 5.
